prbs_byte_checker: RTL and testbench

Downstream consumer of the 8-bit Fibonacci LFSR pattern generator. It receives one byte per valid strobe, self-synchronises to the generator sequence, declares lock, and then counts good and errored bytes. A flywheel reference model is used, so isolated corruption costs one error, not a loss of lock. It is the receive-side check in the link test path; its lock and error outputs drive the board LEDs and the debug readout.

---
 rtl/lfsr_pkg.sv | 23 ++
 rtl/prbs_sat_counter.sv | 22 ++
 rtl/prbs_byte_checker.sv | 130 +++++++++++++
 tb/tb_prbs_byte_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS generator and checker:
// one polynomial definition, the generator seed and the checker state type.
package lfsr_pkg;

   localparam int unsigned LFSR_W    = 8;
   localparam int unsigned TAP_A     = 7;
   localparam int unsigned TAP_B     = 5;
   localparam int unsigned TAP_C     = 4;
   localparam int unsigned TAP_D     = 3;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hAA;

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCKED
   } state_t;

   // 0x00 maps to itself and must never be used as a seed.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
      return {x[LFSR_W-2:0], x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D]};
   endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module prbs_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/prbs_byte_checker.sv
// Self-synchronising PRBS byte checker: seeds from received data, verifies a
// run of predicted bytes, then free-runs a flywheel reference while locked.
module prbs_byte_checker
   import lfsr_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 8,
   parameter int unsigned LOSS_COUNT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       data_in,
   input  logic             data_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic             lock_lost,
   output logic [CNT_W-1:0] good_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);

   state_t              r_state, w_state_nx;
   logic [LFSR_W-1:0]   r_ref, w_ref_nx, w_pred;
   logic [RUN_W-1:0]    r_run, w_run_nx;
   logic [MISS_W-1:0]   r_miss, w_miss_nx;
   logic                r_locked, r_err_pulse, r_lock_lost;
   logic                w_good_inc, w_err_inc, w_lost;

   assign w_pred = lfsr_next(r_ref);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= HUNT;
         r_ref       <= '0;
         r_run       <= '0;
         r_miss      <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_lock_lost <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_ref       <= w_ref_nx;
         r_run       <= w_run_nx;
         r_miss      <= w_miss_nx;
         r_locked    <= (w_state_nx == LOCKED);
         r_err_pulse <= w_err_inc;
         r_lock_lost <= w_lost;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_ref_nx   = r_ref;
      w_run_nx   = r_run;
      w_miss_nx  = r_miss;
      w_good_inc = 1'b0;
      w_err_inc  = 1'b0;
      w_lost     = 1'b0;
      if (data_valid) begin
         unique case (r_state)
            HUNT: begin
               if (data_in != '0) begin
                  w_ref_nx   = data_in;
                  w_run_nx   = '0;
                  w_state_nx = VERIFY;
               end
            end
            VERIFY: begin
               if (data_in == w_pred) begin
                  w_ref_nx = data_in;
                  if (32'(r_run) + 32'd1 == LOCK_COUNT) begin
                     w_run_nx   = '0;
                     w_miss_nx  = '0;
                     w_state_nx = LOCKED;
                  end else begin
                     w_run_nx = r_run + 1'b1;
                  end
               end else if (data_in != '0) begin
                  w_ref_nx = data_in;
                  w_run_nx = '0;
               end else begin
                  w_state_nx = HUNT;
               end
            end
            LOCKED: begin
               // Flywheel: the reference advances on its own and never reseeds from data.
               w_ref_nx = w_pred;
               if (data_in == w_pred) begin
                  w_miss_nx  = '0;
                  w_good_inc = 1'b1;
               end else begin
                  w_err_inc = 1'b1;
                  if (32'(r_miss) + 32'd1 == LOSS_COUNT) begin
                     w_miss_nx  = '0;
                     w_lost     = 1'b1;
                     w_state_nx = HUNT;
                  end else begin
                     w_miss_nx = r_miss + 1'b1;
                  end
               end
            end
            default: w_state_nx = HUNT;
         endcase
      end
   end

   prbs_sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_good_inc),
      .clr   (clr_cnt),
      .q     (good_count)
   );

   prbs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_err_inc),
      .clr   (clr_cnt),
      .q     (err_count)
   );

   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;
   assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_prbs_byte_checker.sv
// Randomised and directed bench for prbs_byte_checker: two instances (default and
// narrow-counter/long-loss) driven in parallel, checked against a rule-level model.
module tb_prbs_byte_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = '0;
   logic       data_valid = 1'b0;
   logic       clr_cnt = 1'b0;

   logic        lk0, ep0, ll0, lk1, ep1, ll1;
   logic [15:0] gc0, ec0;
   logic [3:0]  gc1, ec1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prbs_byte_checker #(.LOCK_COUNT(8), .LOSS_COUNT(4), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .clr_cnt(clr_cnt), .locked(lk0), .err_pulse(ep0), .lock_lost(ll0),
      .good_count(gc0), .err_count(ec0)
   );

   prbs_byte_checker #(.LOCK_COUNT(8), .LOSS_COUNT(32), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .clr_cnt(clr_cnt), .locked(lk1), .err_pulse(ep1), .lock_lost(ll1),
      .good_count(gc1), .err_count(ec1)
   );

   // Reference model, one slot per instance.
   int unsigned p_lock[2] = '{8, 8};
   int unsigned p_loss[2] = '{4, 32};
   int unsigned p_max[2]  = '{65535, 15};

   bit          m_lock[2], m_seeded[2], m_ep[2], m_ll[2];
   logic [7:0]  m_ref[2];
   int unsigned m_run[2], m_miss[2], m_good[2], m_err[2];

   logic [7:0] g;

   function automatic logic [7:0] mnext(input logic [7:0] x);
      return {x[6:0], ^(x & 8'hB8)};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_lock[k] = 0; m_seeded[k] = 0; m_ep[k] = 0; m_ll[k] = 0;
         m_ref[k] = '0; m_run[k] = 0; m_miss[k] = 0; m_good[k] = 0; m_err[k] = 0;
      end
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit c);
      for (int k = 0; k < 2; k++) begin
         m_ep[k] = 0;
         m_ll[k] = 0;
         if (v) begin
            if (m_lock[k]) begin
               m_ref[k] = mnext(m_ref[k]);
               if (d == m_ref[k]) begin
                  m_miss[k] = 0;
                  if (m_good[k] < p_max[k]) m_good[k]++;
               end else begin
                  m_ep[k] = 1;
                  if (m_err[k] < p_max[k]) m_err[k]++;
                  m_miss[k]++;
                  if (m_miss[k] == p_loss[k]) begin
                     m_lock[k] = 0; m_seeded[k] = 0; m_ll[k] = 1; m_miss[k] = 0;
                  end
               end
            end else if (!m_seeded[k]) begin
               if (d != 0) begin
                  m_ref[k] = d; m_run[k] = 0; m_seeded[k] = 1;
               end
            end else if (d == mnext(m_ref[k])) begin
               m_ref[k] = d;
               m_run[k]++;
               if (m_run[k] == p_lock[k]) begin
                  m_lock[k] = 1; m_seeded[k] = 0; m_miss[k] = 0; m_run[k] = 0;
               end
            end else if (d != 0) begin
               m_ref[k] = d; m_run[k] = 0;
            end else begin
               m_seeded[k] = 0;
            end
         end
         if (c) begin
            m_good[k] = 0;
            m_err[k]  = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("lk0", 32'(lk0), 32'(m_lock[0]));
      chk("ep0", 32'(ep0), 32'(m_ep[0]));
      chk("ll0", 32'(ll0), 32'(m_ll[0]));
      chk("gc0", 32'(gc0), m_good[0]);
      chk("ec0", 32'(ec0), m_err[0]);
      chk("lk1", 32'(lk1), 32'(m_lock[1]));
      chk("ep1", 32'(ep1), 32'(m_ep[1]));
      chk("ll1", 32'(ll1), 32'(m_ll[1]));
      chk("gc1", 32'(gc1), m_good[1]);
      chk("ec1", 32'(ec1), m_err[1]);
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, input bit c);
      data_valid = v;
      data_in    = d;
      clr_cnt    = c;
      @(posedge clk);
      model_step(v, d, c);
      #1 compare_all();
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b1, g, 1'b0);
         g = mnext(g);
      end
   endtask

   task automatic wrong(input int n, input bit c);
      for (int i = 0; i < n; i++) begin
         cycle(1'b1, ~g, c);
         g = mnext(g);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; data_valid = 1'b0; clr_cnt = 1'b0; data_in = '0;
      repeat (2) @(posedge clk);
      #1 model_reset();
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      int r;
      model_reset();
      do_reset();

      // Generator stream from power-up seed: lock after the 9th byte.
      g = lfsr_pkg::LFSR_SEED;
      chk("first_byte", 32'(g), 32'h0000_00AA);
      stream(8);
      chk("unlocked_b8", 32'(lk0), 32'd0);
      stream(1);
      chk("locked_b9", 32'(lk0), 32'd1);
      stream(20);
      chk("good20", 32'(gc0), 32'd20);
      chk("err0", 32'(ec0), 32'd0);

      // Single corrupt byte: flywheel keeps alignment.
      wrong(1, 1'b0);
      chk("one_ep", 32'(ep0), 32'd1);
      stream(1);
      chk("flywheel_good", 32'(gc0), 32'd21);
      chk("one_err", 32'(ec0), 32'd1);
      chk("still_locked", 32'(lk0), 32'd1);

      // Four consecutive errors lose lock; stream relocks after seed + 8.
      wrong(4, 1'b0);
      chk("lost_pulse", 32'(ll0), 32'd1);
      chk("lost_unlock", 32'(lk0), 32'd0);
      chk("err5", 32'(ec0), 32'd5);
      stream(8);
      chk("relock_pre", 32'(lk0), 32'd0);
      stream(1);
      chk("relock", 32'(lk0), 32'd1);

      // clr_cnt wins over a same-cycle error increment.
      wrong(1, 1'b1);
      chk("clr_err", 32'(ec0), 32'd0);
      chk("clr_ep", 32'(ep0), 32'd1);

      // Narrow counters saturate.
      wrong(20, 1'b0);
      chk("sat_err", 32'(ec1), 32'hF);
      chk("sat_lock", 32'(lk1), 32'd1);

      // Relock, gapped traffic, then asynchronous reset between edges.
      stream(9);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            cycle(1'b1, g, 1'b0);
            g = mnext(g);
         end else begin
            cycle(1'b0, 8'h00, 1'b0);
         end
      end
      data_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      g = 8'h3C;
      stream(8);
      chk("fresh_pre", 32'(lk0), 32'd0);
      stream(1);
      chk("fresh_lock", 32'(lk0), 32'd1);

      // Zero bytes never seed; a zero in VERIFY returns to HUNT.
      do_reset();
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'h00, 1'b0);
      chk("zero_unlocked", 32'(lk0), 32'd0);
      chk("zero_gc", 32'(gc0), 32'd0);
      cycle(1'b1, 8'h12, 1'b0);
      cycle(1'b1, 8'h00, 1'b0);
      g = mnext(8'h12);
      stream(9);
      chk("zero_relock", 32'(lk0), 32'd1);

      // Random traffic: gaps, corruption, zeros, slips, occasional clears.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            cycle(1'b0, 8'($urandom), ($urandom_range(0, 49) == 0));
         end else begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
               cycle(1'b1, g, ($urandom_range(0, 49) == 0));
            end else if (r < 90) begin
               cycle(1'b1, 8'($urandom), ($urandom_range(0, 49) == 0));
            end else if (r < 95) begin
               cycle(1'b1, 8'h00, ($urandom_range(0, 49) == 0));
            end else begin
               g = mnext(g);
               cycle(1'b1, g, 1'b0);
            end
            g = mnext(g);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
